sr_flag_arbiter: RTL and testbench
==================================

// Module: sr_flag_arbiter
// PURPOSE
//  Round-robin arbiter that shares one bank of SR-semantics status flags between NREQ requesters.
//  Each requester issues a set/reset command {s,r} against one flag index using a req/ack handshake.
//  The block applies at most one command at a time and resolves {s,r}=11 deterministically (never X).
//  It sits between control agents and any logic that consumes the status flags.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  NFLAG  8   number of flag bits in the bank (>=2)
//  IDXW   3   flag index width; must satisfy 2**IDXW >= NFLAG
// PORTS
//  clk     in   1          rising-edge clock
//  rst_n   in   1          asynchronous, active-low reset
//  req     in   NREQ       per-requester request level
//  s       in   NREQ       per-requester set command bit
//  r       in   NREQ       per-requester reset command bit
//  idx     in   NREQ*IDXW  per-requester flag index; requester i uses idx[i*IDXW +: IDXW]
//  ack     out  NREQ       one-hot, one-cycle completion pulse
//  err     out  NREQ       one-cycle pulse alongside ack when the command was illegal
//  q       out  NFLAG      flag bank
//  qbar    out  NFLAG      ~q, combinational
//  busy    out  1          high whenever FSM != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): q=0, qbar=all 1, ack=0, err=0, busy=0, FSM=IDLE, rr_ptr=0.
//  Reset mid-operation: the captured command is discarded, with no flag update and no ack.
//  FSM states: IDLE -> APPLY -> ACK -> IDLE. busy=0 only in IDLE.
//  IDLE:
//   - If req != 0, grant the first set req bit searching from rr_ptr upward, wrapping modulo NREQ.
//   - Capture g, s[g], r[g], idx[g]; go to APPLY.
//   - If req == 0, stay in IDLE.
//  APPLY: update q[idx_c] on the edge leaving APPLY, per {s_c,r_c}:
//   - 00: hold (legal no-op).
//   - 01: q=0.
//   - 10: q=1.
//   - 11: q unchanged, error flagged.
//   - idx_c >= NFLAG: no update, error flagged.
//   Go to ACK.
//  ACK:
//   - ack[g]=1 for exactly this cycle; err[g]=1 in the same cycle if an error was flagged.
//   - rr_ptr <= (g+1) mod NREQ. Go to IDLE.
//  Latency: req sampled at edge k; q updated and ack visible after edge k+1; IDLE again after edge k+2.
//  Throughput: one command per 3 cycles.
//  Handshake:
//   - Inputs are captured once in IDLE, so later changes to s/r/idx or deassertion of req are ignored.
//   - A requester drops req at the edge where it samples ack=1.
//   - If req is still high in the following IDLE cycle, it is a new request.
//   - Such a request ranks last in round-robin after the rr_ptr rotation.
//  Only the granted requester can change q; other requests wait, and no request is lost while req stays high.
//  Starvation bound: a continuously asserted req is served within NREQ grants.
// TESTING
//  T1 reset:
//   - Assert rst_n=0 mid-simulation with no clock edge.
//   - Required: q=8'h00, qbar=8'hFF, ack=0, busy=0 immediately.
//  T2 single set/clear:
//   - req[1]=1, s=1, r=0, idx=5.
//   - Required: q=8'h20 and ack=4'b0010 two edges later.
//   - Then s=0, r=1, idx=5 -> q=8'h00.
//  T3 fairness:
//   - req=4'b1111 held, all commands set the flag idx=i.
//   - Required: ack order 0,1,2,3,0, one every 3 cycles; q=8'h0F after 4 grants.
//  T4 illegal:
//   - q[2]=1, then req[3] with s=1, r=1, idx=2.
//   - Required: ack[3] and err[3] pulse together, q[2] stays 1, no X on q.
//   - Also idx=7 with NFLAG=6: err, no change.
//  T5 hold and stability:
//   - {s,r}=00 -> ack, err=0, q unchanged.
//   - Change s/r/idx during APPLY -> the captured command is applied.
//  T6 reset mid-operation:
//   - Assert rst_n=0 while in APPLY.
//   - Required: no ack, q=0, then normal service from rr_ptr=0 after release.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets NREQ requesters set/reset flags in one shared
// SR-style flag bank, one command at a time via a req/ack handshake.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      s,
    input  logic [NREQ-1:0]      r,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic [NFLAG-1:0]     q,
    output logic [NFLAG-1:0]     qbar,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NFLAG_U = NFLAG;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        ACK
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt;
    logic            s_c;
    logic            r_c;
    logic [IDXW-1:0] idx_c;

    logic [PW-1:0]    pick;
    logic [PW-1:0]    cand;
    logic             pick_vld;
    int               sum;
    logic [NFLAG-1:0] q_nxt;
    logic             bad;
    logic [NREQ-1:0]  gnt_oh;

    // First set req bit at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        cand     = '0;
        sum      = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = PW'(sum);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // {s,r}=11 and out-of-range indices leave the bank untouched.
    always_comb begin
        q_nxt = q;
        bad   = 1'b0;
        if (32'(idx_c) >= NFLAG_U) begin
            bad = 1'b1;
        end else begin
            case ({s_c, r_c})
                2'b00: bad = 1'b0;
                2'b11: bad = 1'b1;
                default: begin
                    for (int f = 0; f < NFLAG; f++) begin
                        if (idx_c == IDXW'(f)) begin
                            q_nxt[f] = s_c;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            s_c    <= 1'b0;
            r_c    <= 1'b0;
            idx_c  <= '0;
            q      <= '0;
            ack    <= '0;
            err    <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= pick;
                        s_c   <= s[pick];
                        r_c   <= r[pick];
                        idx_c <= idx[pick*IDXW +: IDXW];
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    q     <= q_nxt;
                    ack   <= gnt_oh;
                    err   <= bad ? gnt_oh : '0;
                    state <= ACK;
                end
                ACK: begin
                    rr_ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign qbar = ~q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: reset, set/clear, fairness,
// illegal commands, hold, capture stability and reset mid-operation.
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, s, r;
    logic [11:0] idx;
    logic [3:0]  ack, err;
    logic [7:0]  q, qbar;
    logic        busy;

    logic [3:0]  req6, s6, r6;
    logic [11:0] idx6;
    logic [3:0]  ack6, err6;
    logic [5:0]  q6, qbar6;
    logic        busy6;

    int total;
    int bad;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .s    (s),
        .r    (r),
        .idx  (idx),
        .ack  (ack),
        .err  (err),
        .q    (q),
        .qbar (qbar),
        .busy (busy)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) u_dut6 (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req6),
        .s    (s6),
        .r    (r6),
        .idx  (idx6),
        .ack  (ack6),
        .err  (err6),
        .q    (q6),
        .qbar (qbar6),
        .busy (busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int i, input logic sv, input logic rv,
                       input logic [2:0] ix);
        req[i]         = 1'b1;
        s[i]           = sv;
        r[i]           = rv;
        idx[i*3 +: 3]  = ix;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = '0; s = '0; r = '0; idx = '0;
        req6  = '0; s6 = '0; r6 = '0; idx6 = '0;
        cyc(2);
        chk("rst_q", q, 8'h00);
        chk("rst_qbar", qbar, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc(1);

        // T2 set then clear flag 5 from requester 1
        cmd(1, 1'b1, 1'b0, 3'd5);
        cyc(1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_ack_early", ack, 4'b0000);
        cyc(1);
        chk("t2_set_q", q, 8'h20);
        chk("t2_set_qbar", qbar, 8'hDF);
        chk("t2_set_ack", ack, 4'b0010);
        chk("t2_set_err", err, 4'b0000);
        req = '0;
        cyc(1);
        chk("t2_idle_busy", busy, 1'b0);
        chk("t2_idle_ack", ack, 4'b0000);
        cmd(1, 1'b0, 1'b1, 3'd5);
        cyc(2);
        chk("t2_clr_q", q, 8'h00);
        chk("t2_clr_ack", ack, 4'b0010);
        req = '0;
        cyc(1);
        cmd(2, 1'b1, 1'b0, 3'd6);
        cyc(2);
        chk("t2_set6_q", q, 8'h40);
        req = '0;
        cyc(1);

        // T1 async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_q", q, 8'h00);
        chk("t1_qbar", qbar, 8'hFF);
        chk("t1_ack", ack, 4'b0000);
        chk("t1_busy", busy, 1'b0);
        cyc(1);
        rst_n = 1'b1;

        // T3 fairness, all four hold req, each sets its own index
        for (int i = 0; i < 4; i++) cmd(i, 1'b1, 1'b0, 3'(i));
        for (int k = 0; k < 5; k++) begin
            cyc(2);
            chk($sformatf("t3_ack%0d", k), ack, 4'b0001 << (k % 4));
            if (k == 3) chk("t3_q", q, 8'h0F);
            if (k == 4) req = '0;
            cyc(1);
            chk($sformatf("t3_gap%0d", k), ack, 4'b0000);
        end

        // T4 illegal {s,r}=11 on a set flag
        cmd(3, 1'b1, 1'b1, 3'd2);
        cyc(2);
        chk("t4_ack", ack, 4'b1000);
        chk("t4_err", err, 4'b1000);
        chk("t4_q", q, 8'h0F);
        req = '0;
        cyc(1);
        chk("t4_err_clear", err, 4'b0000);

        // T4 out-of-range index on the 6-flag bank
        req6[0] = 1'b1; s6[0] = 1'b1; idx6[2:0] = 3'd7;
        cyc(2);
        chk("t4b_ack", ack6, 4'b0001);
        chk("t4b_err", err6, 4'b0001);
        chk("t4b_q", q6, 6'h00);
        req6 = '0;
        cyc(1);
        req6[1] = 1'b1; s6[1] = 1'b1; idx6[5:3] = 3'd5;
        cyc(2);
        chk("t4b_ok_ack", ack6, 4'b0010);
        chk("t4b_ok_err", err6, 4'b0000);
        chk("t4b_ok_q", q6, 6'h20);
        req6 = '0;
        cyc(1);

        // T5 hold command and capture stability
        cmd(0, 1'b0, 1'b0, 3'd1);
        cyc(2);
        chk("t5_hold_ack", ack, 4'b0001);
        chk("t5_hold_err", err, 4'b0000);
        chk("t5_hold_q", q, 8'h0F);
        req = '0;
        cyc(1);
        cmd(1, 1'b1, 1'b0, 3'd4);
        cyc(1);
        s[1] = 1'b0; r[1] = 1'b1; idx[5:3] = 3'd0; req = '0;
        cyc(1);
        chk("t5_stab_ack", ack, 4'b0010);
        chk("t5_stab_q", q, 8'h1F);
        cyc(1);

        // T6 reset while in APPLY
        cmd(2, 1'b1, 1'b0, 3'd7);
        cyc(1);
        chk("t6_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_q", q, 8'h00);
        chk("t6_ack", ack, 4'b0000);
        chk("t6_busy_rst", busy, 1'b0);
        cyc(1);
        chk("t6_ack_rst", ack, 4'b0000);
        rst_n = 1'b1;
        cmd(0, 1'b1, 1'b0, 3'd3);
        cyc(2);
        chk("t6_rr0_ack", ack, 4'b0001);
        chk("t6_rr0_q", q, 8'h08);
        req[0] = 1'b0;
        cyc(1);
        cyc(2);
        chk("t6_next_ack", ack, 4'b0100);
        chk("t6_next_q", q, 8'h88);
        req = '0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
